// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - handshaked data-memory target with lane steering, extension and error flagging
module dmem_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int IW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam int CW = (LATENCY > 2) ? $clog2(LATENCY - 1) : 1;
  localparam logic [31:0] DEPTH_U = DEPTH_WORDS;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;

  logic [31:0] mem [DEPTH_WORDS];

  logic          cap_write;
  logic [IW+1:0] cap_addr;
  logic [31:0]   cap_wdata;
  logic [1:0]    cap_size;
  logic          cap_signed;

  logic          acc_write;
  logic [IW+1:0] acc_addr;
  logic [31:0]   acc_wdata;
  logic [1:0]    acc_size;
  logic          acc_signed;

  logic          live_err;
  logic          accept;
  logic          access;
  logic [31:0]   rd_word;
  logic [7:0]    rd_byte;
  logic [15:0]   rd_half;
  logic [31:0]   load_val;
  logic [3:0]    be;
  logic [31:0]   wlane;

  // Misaligned, illegal size or beyond the backing array
  function automatic logic req_error(input logic [31:0] addr, input logic [1:0] size);
    logic e;
    e = 1'b0;
    if (size == 2'b11) e = 1'b1;
    if (size == 2'b01 && addr[0]) e = 1'b1;
    if (size == 2'b10 && addr[1:0] != 2'b00) e = 1'b1;
    if ({2'b00, addr[31:2]} >= DEPTH_U) e = 1'b1;
    return e;
  endfunction

  assign live_err = req_error(req_addr, req_size);
  assign accept   = (state == S_IDLE) && req_valid;

  // With LATENCY=1 the access happens on the accept edge, so it uses the live request
  assign acc_write  = (state == S_IDLE) ? req_write            : cap_write;
  assign acc_addr   = (state == S_IDLE) ? req_addr[IW+1:0]     : cap_addr;
  assign acc_wdata  = (state == S_IDLE) ? req_wdata            : cap_wdata;
  assign acc_size   = (state == S_IDLE) ? req_size             : cap_size;
  assign acc_signed = (state == S_IDLE) ? req_signed           : cap_signed;

  assign access = ((state == S_WAIT) && (cnt == '0)) ||
                  ((LATENCY == 1) && accept && !live_err);

  assign rd_word = mem[acc_addr[IW+1:2]];

  // Load lane selection and extension, store lane enables and replicated data
  always_comb begin
    rd_byte  = 8'h00;
    rd_half  = acc_addr[1] ? rd_word[31:16] : rd_word[15:0];
    load_val = rd_word;
    be       = 4'b1111;
    wlane    = acc_wdata;
    case (acc_addr[1:0])
      2'd0:    rd_byte = rd_word[7:0];
      2'd1:    rd_byte = rd_word[15:8];
      2'd2:    rd_byte = rd_word[23:16];
      default: rd_byte = rd_word[31:24];
    endcase
    case (acc_size)
      2'b00: begin
        load_val = {{24{acc_signed & rd_byte[7]}}, rd_byte};
        be       = 4'b0001 << acc_addr[1:0];
        wlane    = {4{acc_wdata[7:0]}};
      end
      2'b01: begin
        load_val = {{16{acc_signed & rd_half[15]}}, rd_half};
        be       = acc_addr[1] ? 4'b1100 : 4'b0011;
        wlane    = {2{acc_wdata[15:0]}};
      end
      default: begin
        load_val = rd_word;
        be       = 4'b1111;
        wlane    = acc_wdata;
      end
    endcase
  end

  // Store commit on the access edge; the array itself is never reset
  always_ff @(posedge clk) begin
    if (access && acc_write && reset) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[acc_addr[IW+1:2]][8*i +: 8] <= wlane[8*i +: 8];
      end
    end
  end

  // State and latency counter register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  // Next state and handshake outputs
  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    case (state)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          if (live_err || LATENCY == 1) begin
            state_n = S_RESP;
          end else begin
            state_n = S_WAIT;
            cnt_n   = CW'((LATENCY > 1) ? LATENCY - 2 : 0);
          end
        end
      end
      S_WAIT: begin
        if (cnt == '0) state_n = S_RESP;
        else           cnt_n   = cnt - 1'b1;
      end
      S_RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  // Request capture and response data, held stable through RESP
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cap_write  <= 1'b0;
      cap_addr   <= '0;
      cap_wdata  <= '0;
      cap_size   <= 2'b00;
      cap_signed <= 1'b0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
    end else begin
      if (accept) begin
        cap_write  <= req_write;
        cap_addr   <= req_addr[IW+1:0];
        cap_wdata  <= req_wdata;
        cap_size   <= req_size;
        cap_signed <= req_signed;
      end
      if (accept && live_err) begin
        resp_rdata <= '0;
        resp_err   <= 1'b1;
      end else if (access) begin
        resp_rdata <= acc_write ? 32'h0 : load_val;
        resp_err   <= 1'b0;
      end else if (state == S_RESP && resp_ready) begin
        resp_rdata <= '0;
        resp_err   <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - directed bench for dmem_responder at LATENCY 2 and 4 with a byte-level model
module tb_dmem_responder;

  localparam int DEPTH = 64;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_write;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [1:0]  req_size;
  logic        req_signed;
  logic        resp_ready;
  logic [1:0]  rdy;
  logic [1:0]  vld;
  logic [1:0]  er;
  logic [31:0] rd [2];

  dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(2)) u_l2 (
    .clk(clk), .reset(rst_n), .req_valid(req_valid), .req_ready(rdy[0]),
    .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_size(req_size), .req_signed(req_signed), .resp_valid(vld[0]),
    .resp_ready(resp_ready), .resp_rdata(rd[0]), .resp_err(er[0])
  );

  dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(4)) u_l4 (
    .clk(clk), .reset(rst_n), .req_valid(req_valid), .req_ready(rdy[1]),
    .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_size(req_size), .req_signed(req_signed), .resp_valid(vld[1]),
    .resp_ready(resp_ready), .resp_rdata(rd[1]), .resp_err(er[1])
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [7:0]  mm [2][4*DEPTH];
  bit          busy [2];
  bit          committed [2];
  int          vcyc [2];
  logic [31:0] e_rdata [2];
  bit          e_err [2];
  bit          p_write [2];
  logic [31:0] p_addr [2];
  logic [31:0] p_wdata [2];
  logic [1:0]  p_size [2];
  int          acc_cnt [2];
  int          done_cnt [2];
  int          acc_cyc [2];
  int          done_cyc [2];
  logic [31:0] last_rdata [2];
  logic        last_err [2];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int inst, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s u%0d cyc=%0d got=%h want=%h", name, inst, cyc, act, exp);
    end
  endtask

  function automatic int lat_of(input int i);
    return (i == 0) ? 2 : 4;
  endfunction

  function automatic bit m_err(input logic [31:0] a, input logic [1:0] s);
    return (s == 2'b11) || (s == 2'b01 && a[0]) || (s == 2'b10 && a[1:0] != 2'b00) ||
           ((a >> 2) >= 32'(DEPTH));
  endfunction

  function automatic logic [31:0] m_load(input int i, input logic [31:0] a, input logic [1:0] s, input logic sg);
    logic [31:0] v;
    int b;
    b = int'(a);
    if (s == 2'b00) begin
      v = {24'h0, mm[i][b]};
      if (sg && v[7]) v = v | 32'hFFFF_FF00;
    end else if (s == 2'b01) begin
      v = {16'h0, mm[i][b+1], mm[i][b]};
      if (sg && v[15]) v = v | 32'hFFFF_0000;
    end else begin
      v = {mm[i][b+3], mm[i][b+2], mm[i][b+1], mm[i][b]};
    end
    return v;
  endfunction

  task automatic m_store(input int i, input logic [31:0] a, input logic [31:0] d, input logic [1:0] s);
    int n;
    n = 1 << s;
    for (int k = 0; k < n; k++) mm[i][int'(a) + k] = d[8*k +: 8];
  endtask

  // Per-cycle comparison of both responders against the model
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (busy[i] && !committed[i] && cyc >= vcyc[i]) begin
        committed[i] = 1'b1;
        if (p_write[i] && !e_err[i]) m_store(i, p_addr[i], p_wdata[i], p_size[i]);
      end
      if (!rst_n) begin
        check("rst_req_ready", i, 32'(rdy[i]), 32'd1);
        check("rst_resp_valid", i, 32'(vld[i]), 32'd0);
        check("rst_resp_rdata", i, rd[i], 32'd0);
        check("rst_resp_err", i, 32'(er[i]), 32'd0);
        busy[i] = 1'b0;
      end else if (!busy[i]) begin
        check("idle_req_ready", i, 32'(rdy[i]), 32'd1);
        check("idle_resp_valid", i, 32'(vld[i]), 32'd0);
        if (req_valid) begin
          e_err[i]     = m_err(req_addr, req_size);
          e_rdata[i]   = (e_err[i] || req_write) ? 32'h0 : m_load(i, req_addr, req_size, req_signed);
          p_write[i]   = req_write;
          p_addr[i]    = req_addr;
          p_wdata[i]   = req_wdata;
          p_size[i]    = req_size;
          vcyc[i]      = cyc + (e_err[i] ? 1 : lat_of(i));
          busy[i]      = 1'b1;
          committed[i] = 1'b0;
          acc_cnt[i]++;
          acc_cyc[i]   = cyc;
        end
      end else begin
        check("busy_req_ready", i, 32'(rdy[i]), 32'd0);
        check("resp_valid_timing", i, 32'(vld[i]), 32'(cyc >= vcyc[i]));
        if (vld[i]) begin
          check("resp_rdata", i, rd[i], e_rdata[i]);
          check("resp_err", i, 32'(er[i]), 32'(e_err[i]));
          if (resp_ready) begin
            busy[i]       = 1'b0;
            done_cnt[i]++;
            done_cyc[i]   = cyc;
            last_rdata[i] = rd[i];
            last_err[i]   = er[i];
          end
        end
      end
    end
  end

  task automatic wait_cnt(input bit is_acc, input int b0, input int b1, input string what);
    int t;
    t = 0;
    while (t < 100 && (is_acc ? (acc_cnt[0] <= b0 || acc_cnt[1] <= b1)
                              : (done_cnt[0] <= b0 || done_cnt[1] <= b1))) begin
      @(posedge clk);
      t++;
    end
    total++;
    if (t >= 100) begin
      bad++;
      $display("FAIL timeout_%s waited=%0d want<100", what, t);
    end
  endtask

  task automatic drive(input bit w, input logic [31:0] a, input logic [31:0] d, input logic [1:0] s, input bit sg);
    req_write  = w;
    req_addr   = a;
    req_wdata  = d;
    req_size   = s;
    req_signed = sg;
    req_valid  = 1'b1;
  endtask

  task automatic scramble();
    req_valid  = 1'b0;
    req_write  = 1'($urandom);
    req_addr   = $urandom;
    req_wdata  = $urandom;
    req_size   = 2'($urandom);
    req_signed = 1'($urandom);
  endtask

  task automatic send(input bit w, input logic [31:0] a, input logic [31:0] d, input logic [1:0] s, input bit sg);
    int a0, a1, d0, d1;
    a0 = acc_cnt[0]; a1 = acc_cnt[1];
    d0 = done_cnt[0]; d1 = done_cnt[1];
    drive(w, a, d, s, sg);
    wait_cnt(1'b1, a0, a1, "accept");
    #1 scramble();
    wait_cnt(1'b0, d0, d1, "response");
    #1;
  endtask

  task automatic pin(input string name, input logic [31:0] want, input logic want_err);
    for (int i = 0; i < 2; i++) begin
      check({name, "_rdata"}, i, last_rdata[i], want);
      check({name, "_err"}, i, 32'(last_err[i]), 32'(want_err));
    end
  endtask

  initial begin
    int a0, a1, d0, d1, t;
    rst_n = 1'b1;
    resp_ready = 1'b1;
    scramble();
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    send(1, 32'h10, 32'hDEAD_BEEF, 2'b10, 0);
    send(0, 32'h10, 32'h0, 2'b10, 0);           pin("ld_w10", 32'hDEAD_BEEF, 0);
    send(1, 32'h10, 32'h1122_3344, 2'b10, 0);
    send(1, 32'h13, 32'h1234_56A5, 2'b00, 0);
    send(0, 32'h10, 32'h0, 2'b10, 0);           pin("ld_w_merged", 32'hA522_3344, 0);
    send(0, 32'h13, 32'h0, 2'b00, 1);           pin("ld_sb13", 32'hFFFF_FFA5, 0);
    send(0, 32'h13, 32'h0, 2'b00, 0);           pin("ld_ub13", 32'h0000_00A5, 0);
    send(0, 32'h10, 32'h0, 2'b00, 1);           pin("ld_sb10", 32'h0000_0044, 0);
    send(0, 32'h12, 32'h0, 2'b01, 0);           pin("ld_uh12", 32'h0000_A522, 0);
    send(1, 32'h22, 32'hBEEF_8001, 2'b01, 0);
    send(0, 32'h22, 32'h0, 2'b01, 1);           pin("ld_sh22", 32'hFFFF_8001, 0);
    send(0, 32'h22, 32'h0, 2'b01, 0);           pin("ld_uh22", 32'h0000_8001, 0);
    send(0, 32'h21, 32'h0, 2'b01, 1);           pin("ld_h21_misaligned", 32'h0, 1);
    send(1, 32'h0, 32'hCAFE_F00D, 2'b10, 0);
    send(1, 32'(4*DEPTH), 32'h0, 2'b10, 0);     pin("st_oob", 32'h0, 1);
    send(0, 32'h0, 32'h0, 2'b10, 0);            pin("ld_w0_kept", 32'hCAFE_F00D, 0);
    send(0, 32'h0, 32'h0, 2'b11, 0);            pin("ld_size11", 32'h0, 1);
    send(1, 32'h12, 32'hFFFF_FFFF, 2'b10, 0);   pin("st_w_misaligned", 32'h0, 1);
    send(0, 32'h10, 32'h0, 2'b10, 0);           pin("ld_w10_after_err", 32'hA522_3344, 0);

    // Response back-pressure with a waiting request
    resp_ready = 1'b0;
    a0 = acc_cnt[0]; a1 = acc_cnt[1];
    drive(0, 32'h10, 32'h0, 2'b10, 0);
    wait_cnt(1'b1, a0, a1, "hold_accept");
    #1 scramble();
    t = 0;
    while (vld != 2'b11 && t < 100) begin @(posedge clk); t++; end
    check("hold_valid_reached", 0, 32'(t < 100), 32'd1);
    repeat (5) @(posedge clk);
    #1;
    d0 = done_cnt[0]; d1 = done_cnt[1];
    a0 = acc_cnt[0];  a1 = acc_cnt[1];
    drive(0, 32'h13, 32'h0, 2'b00, 0);
    resp_ready = 1'b1;
    wait_cnt(1'b0, d0, d1, "hold_release");
    pin("hold_ld_w10", 32'hA522_3344, 0);
    d0 = done_cnt[0]; d1 = done_cnt[1];
    wait_cnt(1'b1, a0, a1, "post_hold_accept");
    for (int i = 0; i < 2; i++) check("reaccept_gap", i, 32'(acc_cyc[i] - done_cyc[i]), 32'd1);
    #1 scramble();
    wait_cnt(1'b0, d0, d1, "post_hold_resp");
    #1;
    pin("post_hold_ub13", 32'h0000_00A5, 0);

    // Reset one cycle after a store is accepted
    send(1, 32'h40, 32'h0BAD_F00D, 2'b10, 0);
    a0 = acc_cnt[0]; a1 = acc_cnt[1];
    drive(1, 32'h40, 32'h1234_5678, 2'b10, 0);
    wait_cnt(1'b1, a0, a1, "abort_accept");
    #1 scramble();
    @(posedge clk);
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    send(0, 32'h40, 32'h0, 2'b10, 0);
    check("abort_l2_committed", 0, last_rdata[0], 32'h1234_5678);
    check("abort_l4_discarded", 1, last_rdata[1], 32'h0BAD_F00D);

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at cyc=%0d", cyc);
    $fatal(1);
  end

endmodule
